// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, parity modes and
// oversampling constants used by both the receiver and the transmitter.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } uart_state_e;

  localparam int unsigned PARITY_NONE = 0;
  localparam int unsigned PARITY_EVEN = 1;
  localparam int unsigned PARITY_ODD  = 2;

  localparam int unsigned OVERSAMPLE  = 16;
  localparam logic [3:0]  SAMPLE_A    = 4'd7;
  localparam logic [3:0]  SAMPLE_B    = 4'd8;
  localparam logic [3:0]  SAMPLE_C    = 4'd9;
  localparam logic [3:0]  LAST_SAMPLE = 4'(OVERSAMPLE - 1);

  // 2-of-3 vote used to decide each bit from three mid-bit samples.
  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: counts DIV-1 down to 0 and emits a one-cycle
// tick at 0. Holds while disabled; reloads on restart so a new frame starts
// with a full tick period aligned to its start edge.
module uart_baud_tick #(
  parameter int unsigned DIV = 27
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_ena,
  input  logic i_restart,
  output logic o_tick
);

  localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] RELOAD = CW'(DIV - 1);

  logic [CW-1:0] r_cnt;

  // Down-counter with reload on terminal count or restart
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_restart) begin
      r_cnt <= RELOAD;
    end else if (i_ena) begin
      r_cnt <= (r_cnt == '0) ? RELOAD : r_cnt - 1'b1;
    end
  end

  assign o_tick = i_ena & ~i_restart & (r_cnt == '0);

endmodule

// File: rtl/uart_rx.sv
// 8-bit UART receiver, 16x oversampling, 8N1 with optional even/odd parity.
// Delivers bytes on a valid/ready interface with sticky framing, parity and
// overrun flags.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned DIV    = 27,
  parameter int unsigned PARITY = PARITY_NONE
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic       rx_i,
  output logic [7:0] data_o,
  output logic       valid_o,
  input  logic       ready_i,
  output logic       busy_o,
  output logic       frame_err_o,
  output logic       parity_err_o,
  output logic       overrun_o,
  input  logic       clear_i
);

  uart_state_e r_state;
  logic        r_sync1, r_sync2, r_sync_d;
  logic [3:0]  r_sample_cnt;
  logic [2:0]  r_bit_idx;
  logic [7:0]  r_shift;
  logic        r_samp_a, r_samp_b;
  logic        r_par_bad;
  logic [7:0]  r_data;
  logic        r_valid;
  logic        r_frame_err, r_parity_err, r_overrun;

  logic w_fall, w_start, w_tick, w_maj, w_par_exp;
  logic w_stop_dec, w_good, w_frame_err, w_parity_err, w_overrun;

  // Two-flop synchronizer plus one delay stage for edge detection
  // NOTE: these reset to 1 (line idle level) so leaving reset never looks
  // like a start-bit falling edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1  <= 1'b1;
      r_sync2  <= 1'b1;
      r_sync_d <= 1'b1;
    end else begin
      r_sync1  <= rx_i;
      r_sync2  <= r_sync1;
      r_sync_d <= r_sync2;
    end
  end

  assign w_fall  = r_sync_d & ~r_sync2;
  assign w_start = ena & (r_state == ST_IDLE) & w_fall;

  uart_baud_tick #(.DIV(DIV)) u_baud (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_ena     (ena),
    .i_restart (w_start),
    .o_tick    (w_tick)
  );

  assign w_maj     = majority3(r_samp_a, r_samp_b, r_sync2);
  assign w_par_exp = (PARITY == PARITY_ODD) ? ~^r_shift : ^r_shift;

  assign w_stop_dec   = (r_state == ST_STOP) & w_tick & (r_sample_cnt == SAMPLE_C);
  assign w_frame_err  = w_stop_dec & ~w_maj;
  assign w_parity_err = w_stop_dec & w_maj & r_par_bad;
  assign w_good       = w_stop_dec & w_maj & ~r_par_bad;
  assign w_overrun    = w_good & r_valid & ~ready_i;

  // Frame FSM: sample counting, majority sampling and bit shifting
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_sample_cnt <= '0;
      r_bit_idx    <= '0;
      r_shift      <= '0;
      r_samp_a     <= 1'b1;
      r_samp_b     <= 1'b1;
      r_par_bad    <= 1'b0;
    end else if (!ena) begin
      r_state      <= ST_IDLE;
      r_sample_cnt <= '0;
    end else if (r_state == ST_IDLE) begin
      if (w_fall) begin
        r_state      <= ST_START;
        r_sample_cnt <= '0;
        r_bit_idx    <= '0;
        r_par_bad    <= 1'b0;
      end
    end else if (w_tick) begin
      r_sample_cnt <= r_sample_cnt + 1'b1;
      if (r_sample_cnt == SAMPLE_A) r_samp_a <= r_sync2;
      if (r_sample_cnt == SAMPLE_B) r_samp_b <= r_sync2;
      case (r_state)
        ST_START: begin
          if (r_sample_cnt == SAMPLE_C && w_maj) begin
            r_state <= ST_IDLE;
          end else if (r_sample_cnt == LAST_SAMPLE) begin
            r_state   <= ST_DATA;
            r_bit_idx <= '0;
          end
        end
        ST_DATA: begin
          if (r_sample_cnt == SAMPLE_C) r_shift <= {w_maj, r_shift[7:1]};
          if (r_sample_cnt == LAST_SAMPLE) begin
            if (r_bit_idx == 3'd7) begin
              r_state <= (PARITY != PARITY_NONE) ? ST_PARITY : ST_STOP;
            end else begin
              r_bit_idx <= r_bit_idx + 1'b1;
            end
          end
        end
        ST_PARITY: begin
          if (r_sample_cnt == SAMPLE_C)    r_par_bad <= (w_maj != w_par_exp);
          if (r_sample_cnt == LAST_SAMPLE) r_state   <= ST_STOP;
        end
        ST_STOP: begin
          // Leave on the decision so a back-to-back start bit is not missed.
          if (r_sample_cnt == SAMPLE_C) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Output holding register, valid/ready handshake and sticky error flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data       <= '0;
      r_valid      <= 1'b0;
      r_frame_err  <= 1'b0;
      r_parity_err <= 1'b0;
      r_overrun    <= 1'b0;
    end else begin
      if (r_valid && ready_i) r_valid <= 1'b0;
      if (w_good && (!r_valid || ready_i)) begin
        r_data  <= r_shift;
        r_valid <= 1'b1;
      end
      // NOTE: clear is written before the set terms so that, within one
      // always_ff, the later non-blocking set wins when both occur.
      if (clear_i) begin
        r_frame_err  <= 1'b0;
        r_parity_err <= 1'b0;
        r_overrun    <= 1'b0;
      end
      if (w_frame_err)  r_frame_err  <= 1'b1;
      if (w_parity_err) r_parity_err <= 1'b1;
      if (w_overrun)    r_overrun    <= 1'b1;
    end
  end

  assign data_o       = r_data;
  assign valid_o      = r_valid;
  assign busy_o       = (r_state != ST_IDLE);
  assign frame_err_o  = r_frame_err;
  assign parity_err_o = r_parity_err;
  assign overrun_o    = r_overrun;

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
8-bit UART receiver with 16x oversampling. Pairs with the team's UART transmitter on the same serial line. Samples an asynchronous rx line, recovers 8N1 frames (optional parity) and presents bytes on a valid/ready interface to the tt_uart top-level glue. Detects framing, parity and overrun errors with sticky flags.

Parameters:
DIV, 27, clk cycles per oversample tick (baud = f_clk / (16*DIV)); legal 1..65535
PARITY, 0, 0 = none, 1 = even, 2 = odd

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
ena  input  1  block enable; low forces idle
rx_i  input  1  asynchronous serial input, idle high
data_o  output  8  received byte, LSB first on line
valid_o  output  1  data_o holds an unconsumed byte
ready_i  input  1  consumer accepts byte when valid_o & ready_i
busy_o  output  1  frame reception in progress (state != IDLE)
frame_err_o  output  1  sticky: stop bit sampled 0
parity_err_o  output  1  sticky: parity mismatch
overrun_o  output  1  sticky: byte completed while valid_o high and not accepted
clear_i  input  1  synchronous clear of all three sticky flags

Behaviour:
- Reset: data_o=0, valid_o=0, busy_o=0, all flags 0, synchronizer flops=1, state IDLE, counters 0.
- rx_i passes through a 2-flop synchronizer (reset value 1). All decisions use the synchronized value.
- Tick generator: counter DIV-1..0; one-cycle tick at 0. Runs only when ena=1. Restarts (reloads DIV-1) on start-edge detection.
- Sample counter 0..15 advances per tick. Samples are taken at counts 7, 8 and 9. The bit value is the 2-of-3 majority, decided at count 9. The bit period ends at the count-15 tick.
- States:
  - IDLE: a synchronized falling edge (prev 1, now 0) -> START, sample count 0.
  - START: majority=1 at count 9 -> IDLE (glitch rejected, no flag). Otherwise -> DATA at end of bit.
  - DATA: 8 bits shifted LSB first. After bit 7 -> PARITY if PARITY!=0, else STOP.
  - PARITY: compare the majority bit with the computed even/odd parity; remember mismatch -> STOP.
  - STOP: decision at count 9, then -> IDLE immediately, without waiting for count 15. This allows back-to-back frames.
- Stop decision outcomes:
  - stop=0: byte discarded, frame_err_o<=1.
  - else parity mismatch: byte discarded, parity_err_o<=1.
  - else byte good.
- Good byte delivery: valid_o and data_o update on the clk after the stop-decision tick (latency 1).
  - If valid_o=1 and ready_i=0 in that cycle: new byte dropped, data_o unchanged, overrun_o<=1.
  - Simultaneous accept and new byte: load the new byte, valid_o stays 1, no overrun.
- Handshake: valid_o falls the cycle after valid_o & ready_i. data_o is stable while valid_o=1. ready_i while valid_o=0 is ignored.
- clear_i clears the flags. A set event in the same cycle wins (flag=1).
- ena=0 mid-frame: abort to IDLE next cycle, partial byte discarded, no flags. The valid/data holding register and the flags are retained.
- rst_n asserted anywhere: immediate return to reset values.

Decomposition:
- Package uart_pkg: state encoding (IDLE, START, DATA, PARITY, STOP), PARITY_NONE/EVEN/ODD constants, OVERSAMPLE=16, SAMPLE_A/B/C=7/8/9, LAST_SAMPLE=15. Shared with the transmitter.
- Sub-module uart_baud_tick (DIV counter with restart and enable). Same module is reusable by the transmitter.

Test Plan:
- DIV=1, PARITY=0, ready_i=1: send 0xA5 at 16 clk/bit -> single valid_o handshake with data_o=0xA5, all flags 0, busy_o low after stop sample.
- Idle line, rx_i low for 4 clk -> START rejected at sample 9, busy_o returns 0, no valid_o, no flags. Then a full 0x5A frame received correctly.
- Invert only sample 8 of every data bit while sending 0x3C -> majority recovers data_o=0x3C. Then send 0x3C with stop=0 -> no valid, frame_err_o=1 until clear_i pulse.
- ready_i=0: send 0x11 then 0x22 back-to-back -> data_o=0x11, valid_o=1, overrun_o=1. Pulse ready_i -> valid_o drops next clk. Repeat with ready_i asserted exactly in the completion cycle -> data_o=0x22, no overrun.
- PARITY=1: send 0x07 with parity bit 1 -> data_o=0x07. Send 0x07 with parity bit 0 -> no valid, parity_err_o=1. PARITY=2 with parity bit 0 -> 0x07 accepted.
- rst_n pulsed low during data bit 3, and separately ena dropped mid-frame -> reset: all outputs 0, busy_o=0. ena abort: busy_o=0 next clk, a prior pending byte still valid. Next full frame received correctly.
